arm: RTL and testbench
======================

Name: arm

Overview:
- Single-cycle 32-bit processor executing a subset of the ARM (A32) instruction set.
- Contains:
  - 32-word instruction memory `_ins_mem`
  - 64-word data memory `_data_mem`
  - 16x32 register file `_register_file`
  - ALU, NZCV flag register, PC
- Top of the CPU hierarchy. Has no data ports; benches load memories and observe state through hierarchical names.

Parameters:
- INS_MEM_SIZE, 32, instruction memory depth in 32-bit words.
- DATA_MEM_SIZE, 64, data memory depth in 32-bit words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (port names clk, rst).
- Required hierarchical names:
  - Top level: pc[31:0], instruction[31:0], reg_write, nzcv_n[3:0].
  - `_ins_mem.mem[0:31]`.
  - `_data_mem.mem[0:63]`, `_data_mem.mem_write`, `_data_mem.addr`, `_data_mem.write_data`.
  - `_register_file.write_addr[3:0]`, `_register_file.write_data[31:0]`.
- Reset (rst=0, asynchronous): pc=0; R0-R14=0; NZCV=0. Memories are not cleared.
- Fetch: instruction = _ins_mem.mem[pc[6:2]], combinational. Addresses at or above INS_MEM_SIZE*4 return 0 (condition EQ with flags clear, so it is not executed).
- Per cycle: decode, execute and write back. Register, flag, memory and PC updates all commit on the same rising edge, so each instruction retires in one cycle.
- Register reads of R15 return pc+8.
- Condition field [31:28]: all 15 ARM conditions EQ..AL are evaluated on the current NZCV. On a failed condition there are no register, memory or flag writes and pc advances by 4.
- Data processing ([27:26]=00):
  - Opcodes: AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN.
  - Operand2 with I=1: imm8 rotated right by 2*rot4.
  - Operand2 with I=0: Rm shifted by imm5 using LSL/LSR/ASR/ROR. LSR/ASR with #0 means #32. ROR #0 means RRX.
  - Register-specified shifts are not supported; they are treated as shift amount 0.
  - S=1 updates NZCV:
    - Arithmetic ops: C = carry out, inverted-borrow convention for subtracts; V = signed overflow.
    - Logical ops: C = shifter carry-out; V unchanged.
  - TST, TEQ, CMP and CMN never write Rd.
  - nzcv_n is the combinational next-flag value; it equals the current flags when no update occurs.
- Single data transfer ([27:26]=01, word only):
  - LDR/STR with 12-bit immediate offset; U selects add or subtract.
  - P=1: pre-indexed. P=0: post-indexed, with writeback always.
  - W=1 performs base writeback.
  - Data memory index = effective_address[7:2] (word-addressed, wraps modulo 64).
  - STR writes Rd's value on the clock edge. LDR reads combinationally and writes Rd on the edge.
  - If the same register is both the load target and the writeback base, the loaded value wins.
- Branch ([27:25]=101):
  - Target = pc + 8 + sign_extend(imm24)<<2.
  - L=1 also writes pc+4 to R14.
- Writes to R15 through data processing or LDR load pc with the value [31:2],00.
- Undefined or other encodings behave as NOP with pc+4.
- reg_write, write_addr and write_data reflect the register-file write port for the current cycle. mem_write, addr and write_data reflect the data-memory write port.
- PC wraps naturally at 32 bits. Execution beyond INS_MEM_SIZE*4 continues harmlessly, executing the 0 words.
- Reset asserted mid-program immediately forces the reset state. Data memory contents are retained.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> pc=0, all registers 0; pc=4 after the first edge.
- Program MOV R1,#5; MOV R2,#7; ADD R3,R1,R2; STR R3,[R0,#0] -> mem[0]=0x0000000C; reg_write pulses with write_addr 1, 2, 3.
- Flags: MOV R1,#1; SUBS R2,R1,#1; MOVEQ R4,#0xFF; MOVNE R5,#1; STR R4,[R0,#4]; STR R5,[R0,#8] -> mem[1]=0xFF, mem[2]=0, NZCV after SUBS = 0110.
- Load/store with preloaded mem[3]=0x12345678: MOV R6,#12; LDR R7,[R6]; ADD R7,R7,R7,LSL#1; STR R7,[R6,#4]! -> mem[4]=0x369D0368, R6=16.
- Branch/loop: a countdown loop with SUBS, BNE and BL storing a counter each iteration -> stored sequence matches the expected image. Run terminates when pc>=128 and all 64 data words match the golden file.
- Rotated immediate and shifts: MOV R1,#0xFF000000 (imm 0xFF rot 4); MOV R2,R1,ASR#4; store -> 0xFFF00000. Also LSR#0 (meaning #32) -> 0.

Source files
------------

// File: rtl/arm.sv
// Single-cycle ARM (A32 subset) core: data processing, word LDR/STR with
// immediate offset, B/BL. Instruction and data memories are internal arrays.

module _ins_mem #(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [31:0]              rdata
);
  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  assign rdata = mem[addr];
endmodule

module _data_mem #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     mem_write,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data
);
  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (mem_write) mem[addr] <= write_data;
  end

  assign read_data = mem[addr];
endmodule

module _register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_plus8,
  input  logic [3:0]  ra_addr,
  input  logic [3:0]  rb_addr,
  input  logic [3:0]  rc_addr,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  output logic [31:0] rc_data,
  input  logic        reg_write,
  input  logic [3:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data
);
  logic [31:0] regs_q [0:14];
  logic [31:0] regs_d [0:14];

  // R15 is not stored here; reads see pc+8 and writes to it are dropped.
  assign ra_data = (ra_addr == 4'hF) ? pc_plus8 : regs_q[ra_addr];
  assign rb_data = (rb_addr == 4'hF) ? pc_plus8 : regs_q[rb_addr];
  assign rc_data = (rc_addr == 4'hF) ? pc_plus8 : regs_q[rc_addr];

  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_addr != 4'hF) regs_d[wb_addr] = wb_data;
    if (reg_write && write_addr != 4'hF) regs_d[write_addr] = write_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end
endmodule

module arm #(
  parameter int unsigned INS_MEM_SIZE  = 32,
  parameter int unsigned DATA_MEM_SIZE = 64
) (
  input logic clk,
  input logic rst
);
  localparam int unsigned IAW = $clog2(INS_MEM_SIZE);
  localparam int unsigned DAW = $clog2(DATA_MEM_SIZE);

  typedef enum logic [1:0] {CLS_NOP, CLS_DP, CLS_SDT, CLS_BR} cls_e;
  typedef enum logic [3:0] {
    OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
    OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
  } alu_op_e;

  logic [31:0] pc_q, pc_d, pc, pc_plus4, pc_plus8, instruction, ins_rdata;
  logic [3:0]  nzcv_q, nzcv_n;
  logic        reg_write, wb_en, mem_write, cond_pass, pc_load;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata, rn_val, rd_val, rm_val, mem_rdata, pc_load_val;
  logic [31:0] op2, alu_x, alu_y, alu_res, sdt_calc, sdt_ea, br_target;
  logic [32:0] sum, tmp33;
  logic [5:0]  rot_amt;
  logic [4:0]  amt;
  logic        shc, alu_cin, alu_arith, sdt_wb, n_f, z_f, c_f, v_f;
  cls_e        cls;
  alu_op_e     op;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;
  assign {n_f, z_f, c_f, v_f} = nzcv_q;

  _ins_mem #(.DEPTH(INS_MEM_SIZE)) _ins_mem (
    .clk(clk), .load_en(1'b0), .load_addr('0), .load_data('0),
    .addr(pc_q[IAW+1:2]), .rdata(ins_rdata)
  );

  assign instruction = (pc_q < 32'(INS_MEM_SIZE * 4)) ? ins_rdata : '0;

  _register_file _register_file (
    .clk(clk), .rst(rst), .pc_plus8(pc_plus8),
    .ra_addr(instruction[19:16]), .rb_addr(instruction[15:12]), .rc_addr(instruction[3:0]),
    .ra_data(rn_val), .rb_data(rd_val), .rc_data(rm_val),
    .reg_write(reg_write), .write_addr(rf_waddr), .write_data(rf_wdata),
    .wb_en(wb_en), .wb_addr(instruction[19:16]), .wb_data(sdt_calc)
  );

  _data_mem #(.DEPTH(DATA_MEM_SIZE)) _data_mem (
    .clk(clk), .mem_write(mem_write), .addr(sdt_ea[DAW+1:2]),
    .write_data(rd_val), .read_data(mem_rdata)
  );

  assign op  = alu_op_e'(instruction[24:21]);
  assign amt = instruction[11:7];

  always_comb begin
    unique case (instruction[31:28])
      4'h0:    cond_pass = z_f;
      4'h1:    cond_pass = !z_f;
      4'h2:    cond_pass = c_f;
      4'h3:    cond_pass = !c_f;
      4'h4:    cond_pass = n_f;
      4'h5:    cond_pass = !n_f;
      4'h6:    cond_pass = v_f;
      4'h7:    cond_pass = !v_f;
      4'h8:    cond_pass = c_f && !z_f;
      4'h9:    cond_pass = !c_f || z_f;
      4'hA:    cond_pass = n_f == v_f;
      4'hB:    cond_pass = n_f != v_f;
      4'hC:    cond_pass = !z_f && (n_f == v_f);
      4'hD:    cond_pass = z_f || (n_f != v_f);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    cls = CLS_NOP;
    if (instruction[27:26] == 2'b00) cls = CLS_DP;
    else if (instruction[27:25] == 3'b010 && !instruction[22]) cls = CLS_SDT;
    else if (instruction[27:25] == 3'b101) cls = CLS_BR;
  end

  // Barrel shifter; a zero amount encodes #32 for LSR/ASR and RRX for ROR.
  always_comb begin
    op2     = rm_val;
    shc     = c_f;
    rot_amt = '0;
    tmp33   = '0;
    if (instruction[25]) begin
      rot_amt = {1'b0, instruction[11:8], 1'b0};
      op2 = ({24'b0, instruction[7:0]} >> rot_amt) | ({24'b0, instruction[7:0]} << (6'd32 - rot_amt));
      if (instruction[11:8] != 4'h0) shc = op2[31];
    end else if (!instruction[4]) begin
      unique case (instruction[6:5])
        2'b00: if (amt != 5'd0) begin
          tmp33 = {1'b0, rm_val} << amt;
          op2 = tmp33[31:0];
          shc = tmp33[32];
        end
        2'b01: if (amt == 5'd0) begin
          op2 = '0;
          shc = rm_val[31];
        end else begin
          tmp33 = {rm_val, 1'b0} >> amt;
          op2 = tmp33[32:1];
          shc = tmp33[0];
        end
        2'b10: if (amt == 5'd0) begin
          op2 = {32{rm_val[31]}};
          shc = rm_val[31];
        end else begin
          tmp33 = $signed({rm_val, 1'b0}) >>> amt;
          op2 = tmp33[32:1];
          shc = tmp33[0];
        end
        default: if (amt == 5'd0) begin
          op2 = {c_f, rm_val[31:1]};
          shc = rm_val[0];
        end else begin
          op2 = (rm_val >> amt) | (rm_val << (6'd32 - {1'b0, amt}));
          shc = op2[31];
        end
      endcase
    end
  end

  // Subtracts are folded into a single adder as x + ~y + cin.
  always_comb begin
    alu_x     = rn_val;
    alu_y     = op2;
    alu_cin   = 1'b0;
    alu_arith = 1'b1;
    unique case (op)
      OP_SUB, OP_CMP: begin alu_y = ~op2;    alu_cin = 1'b1; end
      OP_RSB:         begin alu_x = ~rn_val; alu_y = op2; alu_cin = 1'b1; end
      OP_ADC:         alu_cin = c_f;
      OP_SBC:         begin alu_y = ~op2;    alu_cin = c_f; end
      OP_RSC:         begin alu_x = ~rn_val; alu_cin = c_f; end
      OP_ADD, OP_CMN: alu_cin = 1'b0;
      default:        alu_arith = 1'b0;
    endcase
    sum = {1'b0, alu_x} + {1'b0, alu_y} + {32'b0, alu_cin};
    unique case (op)
      OP_AND, OP_TST: alu_res = rn_val & op2;
      OP_EOR, OP_TEQ: alu_res = rn_val ^ op2;
      OP_ORR:         alu_res = rn_val | op2;
      OP_MOV:         alu_res = op2;
      OP_BIC:         alu_res = rn_val & ~op2;
      OP_MVN:         alu_res = ~op2;
      default:        alu_res = sum[31:0];
    endcase
  end

  assign sdt_calc  = instruction[23] ? rn_val + {20'b0, instruction[11:0]}
                                     : rn_val - {20'b0, instruction[11:0]};
  assign sdt_ea    = instruction[24] ? sdt_calc : rn_val;
  assign sdt_wb    = !instruction[24] || instruction[21];
  assign br_target = pc_plus8 + {{6{instruction[23]}}, instruction[23:0], 2'b00};

  always_comb begin
    pc_d        = pc_plus4;
    nzcv_n      = nzcv_q;
    reg_write   = 1'b0;
    rf_waddr    = instruction[15:12];
    rf_wdata    = alu_res;
    wb_en       = 1'b0;
    mem_write   = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = alu_res;
    if (cond_pass) begin
      unique case (cls)
        CLS_DP: begin
          if (instruction[20]) begin
            nzcv_n[3] = alu_res[31];
            nzcv_n[2] = alu_res == '0;
            nzcv_n[1] = alu_arith ? sum[32] : shc;
            if (alu_arith) nzcv_n[0] = (alu_x[31] == alu_y[31]) && (sum[31] != alu_x[31]);
          end
          if (instruction[24:23] != 2'b10) begin
            if (instruction[15:12] == 4'hF) pc_load = 1'b1;
            else reg_write = 1'b1;
          end
        end
        CLS_SDT: begin
          if (instruction[20]) begin
            pc_load_val = mem_rdata;
            rf_wdata    = mem_rdata;
            if (instruction[15:12] == 4'hF) pc_load = 1'b1;
            else reg_write = 1'b1;
            // The loaded value takes precedence over base writeback.
            wb_en = sdt_wb && (instruction[19:16] != instruction[15:12]);
          end else begin
            mem_write = 1'b1;
            reg_write = sdt_wb;
            rf_waddr  = instruction[19:16];
            rf_wdata  = sdt_calc;
          end
        end
        CLS_BR: begin
          pc_d = br_target;
          if (instruction[24]) begin
            reg_write = 1'b1;
            rf_waddr  = 4'hE;
            rf_wdata  = pc_plus4;
          end
        end
        default: ;
      endcase
    end
    if (pc_load) pc_d = {pc_load_val[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= '0;
      nzcv_q <= '0;
    end else begin
      pc_q   <= pc_d;
      nzcv_q <= nzcv_n;
    end
  end
endmodule

// File: tb/tb_arm.sv
// Directed program bench for arm: expected register writes and stores are
// queued with each program and retired as the core performs them.
`timescale 1ns/1ps

module tb_arm;
  logic clk = 1'b0;
  logic rst = 1'b0;

  arm #(.INS_MEM_SIZE(32), .DATA_MEM_SIZE(64)) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  typedef struct { logic [3:0] a; logic [31:0] d; } rexp_t;
  typedef struct { logic [5:0] a; logic [31:0] d; } sexp_t;

  rexp_t       rq[$];
  sexp_t       sq[$];
  logic [31:0] prog   [0:31];
  logic [31:0] golden [0:63];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        flag_on = 1'b0;
  logic [31:0] flag_pc;
  logic [3:0]  flag_exp;

  localparam logic [3:0] AL = 4'hE;
  localparam logic [3:0] OP_SUB = 4'h2, OP_ADD = 4'h4, OP_MOV = 4'hD;

  function automatic logic [31:0] dp_imm(input logic [3:0] c, input logic [3:0] op, input logic s,
      input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rot, input logic [7:0] imm);
    return {c, 2'b00, 1'b1, op, s, rn, rd, rot, imm};
  endfunction

  function automatic logic [31:0] dp_reg(input logic [3:0] c, input logic [3:0] op, input logic s,
      input logic [3:0] rn, input logic [3:0] rd, input logic [4:0] sa, input logic [1:0] sh, input logic [3:0] rm);
    return {c, 2'b00, 1'b0, op, s, rn, rd, sa, sh, 1'b0, rm};
  endfunction

  function automatic logic [31:0] sdt(input logic p, input logic u, input logic w, input logic l,
      input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] off);
    return {AL, 2'b01, 1'b0, p, u, 1'b0, w, l, rn, rd, off};
  endfunction

  function automatic logic [31:0] br(input logic [3:0] c, input logic l, input logic [23:0] off);
    return {c, 3'b101, l, off};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_reg(input logic [3:0] a, input logic [31:0] d);
    rexp_t e;
    e.a = a; e.d = d;
    rq.push_back(e);
  endtask

  task automatic exp_store(input logic [5:0] a, input logic [31:0] d);
    sexp_t e;
    e.a = a; e.d = d;
    sq.push_back(e);
    golden[a] = d;
  endtask

  // Called with outputs settled mid-cycle; retires what the current instruction does.
  task automatic tick(input logic [31:0] end_pc);
    rexp_t r;
    sexp_t s;
    if (flag_on && dut.pc == flag_pc) begin
      chk("nzcv_next", 32'(dut.nzcv_n), 32'(flag_exp));
      flag_on = 1'b0;
    end
    if (dut.pc < end_pc && dut.reg_write) begin
      vectors++;
      assert (rq.size() != 0) else begin
        miscompares++;
        $error("FAIL reg_write_extra: observed write r%0d=%h expected none",
               dut._register_file.write_addr, dut._register_file.write_data);
      end
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("reg_write_addr", 32'(dut._register_file.write_addr), 32'(r.a));
        chk("reg_write_data", dut._register_file.write_data, r.d);
      end
    end
    if (dut._data_mem.mem_write) begin
      vectors++;
      assert (sq.size() != 0) else begin
        miscompares++;
        $error("FAIL store_extra: observed store [%0d]=%h expected none",
               dut._data_mem.addr, dut._data_mem.write_data);
      end
      if (sq.size() != 0) begin
        s = sq.pop_front();
        chk("store_addr", 32'(dut._data_mem.addr), 32'(s.a));
        chk("store_data", dut._data_mem.write_data, s.d);
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic run_prog(input int unsigned n, input logic [31:0] end_pc);
    int unsigned cyc;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) dut._ins_mem.mem[i] = (i < int'(n)) ? prog[i] : '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", dut.pc, 32'd0);
    chk("reset_nzcv", 32'(dut.nzcv_n), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tick(end_pc);
    chk("first_edge_pc", dut.pc, 32'd4);
    cyc = 1;
    while (dut.pc < end_pc && cyc < 400) begin
      tick(end_pc);
      cyc++;
    end
    chk("prog_done", 32'(dut.pc >= end_pc), 32'd1);
    chk("reg_queue_drained", 32'(rq.size()), 32'd0);
    chk("store_queue_drained", 32'(sq.size()), 32'd0);
    chk("flag_check_reached", 32'(flag_on), 32'd0);
    rq.delete();
    sq.delete();
    flag_on = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      golden[i] = 32'hA500_0000 | 32'(i);
      if (i == 3) golden[i] = 32'h1234_5678;
      dut._data_mem.mem[i] = golden[i];
    end

    // Basic ALU and store
    prog[0] = dp_imm(AL, OP_MOV, 1'b0, 4'd0, 4'd1, 4'd0, 8'd5);
    prog[1] = dp_imm(AL, OP_MOV, 1'b0, 4'd0, 4'd2, 4'd0, 8'd7);
    prog[2] = dp_reg(AL, OP_ADD, 1'b0, 4'd1, 4'd3, 5'd0, 2'b00, 4'd2);
    prog[3] = sdt(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 12'd0);
    exp_reg(4'd1, 32'd5); exp_reg(4'd2, 32'd7); exp_reg(4'd3, 32'd12);
    exp_store(6'd0, 32'h0000_000C);
    run_prog(4, 32'd16);

    // Flags and conditional execution
    prog[0] = dp_imm(AL, OP_MOV, 1'b0, 4'd0, 4'd1, 4'd0, 8'd1);
    prog[1] = dp_imm(AL, OP_SUB, 1'b1, 4'd1, 4'd2, 4'd0, 8'd1);
    prog[2] = dp_imm(4'h0, OP_MOV, 1'b0, 4'd0, 4'd4, 4'd0, 8'hFF);
    prog[3] = dp_imm(4'h1, OP_MOV, 1'b0, 4'd0, 4'd5, 4'd0, 8'd1);
    prog[4] = sdt(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 12'd4);
    prog[5] = sdt(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 12'd8);
    exp_reg(4'd1, 32'd1); exp_reg(4'd2, 32'd0); exp_reg(4'd4, 32'hFF);
    exp_store(6'd1, 32'hFF); exp_store(6'd2, 32'd0);
    flag_on = 1'b1; flag_pc = 32'd4; flag_exp = 4'b0110;
    run_prog(6, 32'd24);

    // Load, shifted add, pre-indexed store with writeback
    prog[0] = dp_imm(AL, OP_MOV, 1'b0, 4'd0, 4'd6, 4'd0, 8'd12);
    prog[1] = sdt(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 4'd7, 12'd0);
    prog[2] = dp_reg(AL, OP_ADD, 1'b0, 4'd7, 4'd7, 5'd1, 2'b00, 4'd7);
    prog[3] = sdt(1'b1, 1'b1, 1'b1, 1'b0, 4'd6, 4'd7, 12'd4);
    exp_reg(4'd6, 32'd12); exp_reg(4'd7, 32'h1234_5678);
    exp_reg(4'd7, 32'h369D_0368); exp_reg(4'd6, 32'd16);
    exp_store(6'd4, 32'h369D_0368);
    run_prog(4, 32'd16);

    // Countdown loop: BL to a post-indexed store, return via MOV PC,LR
    for (int i = 0; i < 32; i++) prog[i] = '0;
    prog[0] = dp_imm(AL, OP_MOV, 1'b0, 4'd0, 4'd1, 4'd0, 8'd3);
    prog[1] = dp_imm(AL, OP_MOV, 1'b0, 4'd0, 4'd2, 4'd0, 8'h40);
    prog[2] = br(AL, 1'b1, 24'd3);
    prog[3] = dp_imm(AL, OP_SUB, 1'b1, 4'd1, 4'd1, 4'd0, 8'd1);
    prog[4] = br(4'h1, 1'b0, 24'hFFFFFC);
    prog[5] = br(AL, 1'b0, 24'd25);
    prog[7] = sdt(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 12'd4);
    prog[8] = dp_reg(AL, OP_MOV, 1'b0, 4'd0, 4'd15, 5'd0, 2'b00, 4'd14);
    exp_reg(4'd1, 32'd3); exp_reg(4'd2, 32'h40);
    for (int k = 3; k >= 1; k--) begin
      exp_reg(4'd14, 32'h0C);
      exp_reg(4'd2, 32'h40 + 32'(4 * (4 - k)));
      exp_reg(4'd1, 32'(k - 1));
      exp_store(6'(16 + 3 - k), 32'(k));
    end
    run_prog(9, 32'd128);
    chk("loop_exit_pc", dut.pc, 32'h80);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_pc", dut.pc, 32'd0);
    chk("async_reset_nzcv", 32'(dut.nzcv_n), 32'd0);

    // Rotated immediate, ASR, LSR #32 with carry, RRX
    prog[0] = dp_imm(AL, OP_MOV, 1'b0, 4'd0, 4'd1, 4'd4, 8'hFF);
    prog[1] = dp_reg(AL, OP_MOV, 1'b0, 4'd0, 4'd2, 5'd4, 2'b10, 4'd1);
    prog[2] = sdt(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 12'h50);
    prog[3] = dp_reg(AL, OP_MOV, 1'b1, 4'd0, 4'd3, 5'd0, 2'b01, 4'd1);
    prog[4] = sdt(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 12'h54);
    prog[5] = dp_reg(AL, OP_MOV, 1'b0, 4'd0, 4'd4, 5'd0, 2'b11, 4'd1);
    prog[6] = sdt(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 12'h58);
    exp_reg(4'd1, 32'hFF00_0000); exp_reg(4'd2, 32'hFFF0_0000);
    exp_reg(4'd3, 32'd0); exp_reg(4'd4, 32'hFF80_0000);
    exp_store(6'd20, 32'hFFF0_0000); exp_store(6'd21, 32'd0); exp_store(6'd22, 32'hFF80_0000);
    flag_on = 1'b1; flag_pc = 32'hC; flag_exp = 4'b0110;
    run_prog(7, 32'd28);

    // Signed overflow on subtract and signed conditions
    prog[0] = dp_imm(AL, OP_MOV, 1'b0, 4'd0, 4'd1, 4'd1, 8'd2);
    prog[1] = dp_imm(AL, OP_SUB, 1'b1, 4'd1, 4'd2, 4'd0, 8'd1);
    prog[2] = dp_imm(4'h6, OP_MOV, 1'b0, 4'd0, 4'd3, 4'd0, 8'd9);
    prog[3] = dp_imm(4'hA, OP_MOV, 1'b0, 4'd0, 4'd4, 4'd0, 8'd1);
    prog[4] = dp_imm(4'hB, OP_MOV, 1'b0, 4'd0, 4'd5, 4'd0, 8'd2);
    exp_reg(4'd1, 32'h8000_0000); exp_reg(4'd2, 32'h7FFF_FFFF);
    exp_reg(4'd3, 32'd9); exp_reg(4'd5, 32'd2);
    flag_on = 1'b1; flag_pc = 32'd4; flag_exp = 4'b0011;
    run_prog(5, 32'd20);

    for (int i = 0; i < 64; i++) chk("data_mem_image", dut._data_mem.mem[i], golden[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end
endmodule
